// File: rtl/detect_winner.sv
// rtl/detect_winner.sv - registered tic-tac-toe line, winner, draw and overlap detector
//
// Purpose: examines the two players' square masks every clock and registers
// which of the eight lines are complete, who owns them, whether the board is
// a finished draw, and whether any square is claimed twice.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   ain       in   9  squares held by player A (bit 8 top-left, row-major, bit 0 bottom-right)
//   bin       in   9  squares held by player B (same mapping)
//   win_line  out  8  completed-line flags: [0..2] rows top..bottom, [3..5] columns
//                     left..right, [6] diagonal TL-BR, [7] diagonal TR-BL
//   a_wins    out  1  player A owns at least one complete line
//   b_wins    out  1  player B owns at least one complete line
//   draw      out  1  board full, no winner, no overlap
//   illegal   out  1  at least one square claimed by both players
module detect_winner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] ain,
  input  logic [8:0] bin,
  output logic [7:0] win_line,
  output logic       a_wins,
  output logic       b_wins,
  output logic       draw,
  output logic       illegal
);

  // One bit per line, set when all three squares are held in mask s.
  function automatic logic [7:0] lines_of(input logic [8:0] s);
    lines_of = {s[6] & s[4] & s[2],   // [7] TR-BL diagonal
                s[8] & s[4] & s[0],   // [6] TL-BR diagonal
                s[6] & s[3] & s[0],   // [5] right column
                s[7] & s[4] & s[1],   // [4] middle column
                s[8] & s[5] & s[2],   // [3] left column
                &s[2:0],              // [2] bottom row
                &s[5:3],              // [1] middle row
                &s[8:6]};             // [0] top row
  endfunction

  logic [7:0] a_lines;
  logic [7:0] b_lines;
  logic [7:0] win_line_d, win_line_q;
  logic       a_wins_d, a_wins_q;
  logic       b_wins_d, b_wins_q;
  logic       draw_d, draw_q;
  logic       illegal_d, illegal_q;

  // Lines are taken from the raw masks even when squares overlap, so an
  // illegal board can still report wins for either or both players.
  always_comb begin
    a_lines    = lines_of(ain);
    b_lines    = lines_of(bin);
    win_line_d = a_lines | b_lines;
    a_wins_d   = |a_lines;
    b_wins_d   = |b_lines;
    illegal_d  = |(ain & bin);
    draw_d     = ((ain | bin) == 9'h1FF) && !a_wins_d && !b_wins_d && !illegal_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_line_q <= 8'h00;
      a_wins_q   <= 1'b0;
      b_wins_q   <= 1'b0;
      draw_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      win_line_q <= win_line_d;
      a_wins_q   <= a_wins_d;
      b_wins_q   <= b_wins_d;
      draw_q     <= draw_d;
      illegal_q  <= illegal_d;
    end
  end

  assign win_line = win_line_q;
  assign a_wins   = a_wins_q;
  assign b_wins   = b_wins_q;
  assign draw     = draw_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_detect_winner.sv
// tb/tb_detect_winner.sv - self-checking bench for detect_winner
module tb_detect_winner;

  logic       clk;
  logic       rst_n;
  logic [8:0] ain;
  logic [8:0] bin;
  logic [7:0] win_line;
  logic       a_wins;
  logic       b_wins;
  logic       draw;
  logic       illegal;

  int total;
  int bad;

  detect_winner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ain      (ain),
    .bin      (bin),
    .win_line (win_line),
    .a_wins   (a_wins),
    .b_wins   (b_wins),
    .draw     (draw),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square numbers of each line, indexed by win_line bit.
  int line_sq [8][3] = '{'{8, 7, 6}, '{5, 4, 3}, '{2, 1, 0},
                         '{8, 5, 2}, '{7, 4, 1}, '{6, 3, 0},
                         '{8, 4, 0}, '{6, 4, 2}};

  // Reference: {win_line, a_wins, b_wins, draw, illegal}
  function automatic logic [11:0] model(input logic [8:0] a, input logic [8:0] b);
    logic [7:0] w;
    logic       aw, bw, ill, full;
    int         a_cnt, b_cnt, filled;
    w = 8'h00; aw = 1'b0; bw = 1'b0; ill = 1'b0;
    for (int l = 0; l < 8; l++) begin
      a_cnt = 0; b_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        if (a[line_sq[l][k]]) a_cnt++;
        if (b[line_sq[l][k]]) b_cnt++;
      end
      if (a_cnt == 3) begin w[l] = 1'b1; aw = 1'b1; end
      if (b_cnt == 3) begin w[l] = 1'b1; bw = 1'b1; end
    end
    filled = 0;
    for (int s = 0; s < 9; s++) begin
      if (a[s] && b[s]) ill = 1'b1;
      if (a[s] || b[s]) filled++;
    end
    full = (filled == 9);
    return {w, aw, bw, full && !aw && !bw && !ill, ill};
  endfunction

  function automatic logic [11:0] observed();
    return {win_line, a_wins, b_wins, draw, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a board away from the edge, confirm the previous result holds until
  // the edge, then confirm the new result one edge later.
  task automatic apply(input string tag, input logic [8:0] a, input logic [8:0] b,
                       input logic [11:0] prev_exp);
    @(negedge clk);
    ain = a;
    bin = b;
    #1;
    check({tag, "_hold"}, observed(), prev_exp);
    @(posedge clk);
    #1;
    check(tag, observed(), model(a, b));
  endtask

  typedef struct {
    string      tag;
    logic [8:0] a;
    logic [8:0] b;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] prev;
  logic [8:0]  ra, rb;

  initial begin
    total = 0;
    bad   = 0;
    ain   = 9'h000;
    bin   = 9'h000;
    rst_n = 1'b0;
    #12;
    check("reset_state", observed(), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed boards with hand-derived expected outputs.
    vecs.push_back('{"empty",     9'b000000000, 9'b000000000, {8'b00000000, 4'b0000}});
    vecs.push_back('{"partial",   9'b101000001, 9'b010010100, {8'b00000000, 4'b0000}});
    vecs.push_back('{"partial_w", 9'b101001001, 9'b010010100, {8'b00100000, 4'b1000}});
    vecs.push_back('{"a_top",     9'b111000000, 9'b000000000, {8'b00000001, 4'b1000}});
    vecs.push_back('{"b_mid",     9'b000000000, 9'b000111000, {8'b00000010, 4'b0100}});
    vecs.push_back('{"a_bot",     9'b000000111, 9'b000000000, {8'b00000100, 4'b1000}});
    vecs.push_back('{"b_lcol",    9'b000000000, 9'b100100100, {8'b00001000, 4'b0100}});
    vecs.push_back('{"a_mcol",    9'b010010010, 9'b000000000, {8'b00010000, 4'b1000}});
    vecs.push_back('{"b_rcol",    9'b000000000, 9'b001001001, {8'b00100000, 4'b0100}});
    vecs.push_back('{"a_diag",    9'b100010001, 9'b000000000, {8'b01000000, 4'b1000}});
    vecs.push_back('{"b_adiag",   9'b000000000, 9'b001010100, {8'b10000000, 4'b0100}});
    vecs.push_back('{"full_draw", 9'b010101101, 9'b101010010, {8'b00000000, 4'b0010}});
    vecs.push_back('{"overlap",   9'b100000000, 9'b100000000, {8'b00000000, 4'b0001}});
    vecs.push_back('{"dbl_line",  9'b111010001, 9'b100000000, {8'b01000001, 4'b1001}});
    vecs.push_back('{"both_win",  9'b111000000, 9'b000000111, {8'b00000101, 4'b1100}});
    vecs.push_back('{"full_awin", 9'b111010001, 9'b000101110, {8'b01000001, 4'b1000}});

    prev = 12'h000;
    foreach (vecs[i]) begin
      check({vecs[i].tag, "_ref"}, model(vecs[i].a, vecs[i].b), vecs[i].exp);
      apply(vecs[i].tag, vecs[i].a, vecs[i].b, prev);
      prev = vecs[i].exp;
    end

    // Random boards: mostly legal positions, with occasional overlaps.
    for (int n = 0; n < 400; n++) begin
      ra = 9'($urandom);
      rb = 9'($urandom);
      if ($urandom_range(0, 3) != 0) rb = rb & ~ra;
      apply("random", ra, rb, prev);
      prev = model(ra, rb);
    end

    // Asynchronous reset with a winning board held on the inputs.
    apply("pre_reset", 9'b111000000, 9'b000000111, prev);
    prev = model(9'b111000000, 9'b000000111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), 12'h000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", observed(), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_hold", observed(), 12'h000);
    @(posedge clk);
    #1;
    check("post_release", observed(), prev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
